// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory among NUM_CORES cores, using round-robin or fixed-priority arbitration.
// Each grant runs IDLE -> ISSUE -> (WAIT x MEM_LATENCY for reads) -> DONE, and the core stays stalled until DONE.
module core_mem_arbiter #(
  parameter int NUM_CORES    = 2,
  parameter int MEMORY_WIDTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CORES-1:0]                  core_req_i,
  input  logic [NUM_CORES*MEMORY_WIDTH-1:0]     core_addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]       core_data_i,
  input  logic [NUM_CORES*(DATA_WIDTH/8)-1:0]   core_be_i,
  output logic [NUM_CORES-1:0]                  core_stall_o,
  output logic [DATA_WIDTH-1:0]                 core_data_o,
  output logic                                  mem_en_o,
  output logic [MEMORY_WIDTH-1:0]               mem_addr_o,
  output logic [DATA_WIDTH-1:0]                 mem_data_o,
  output logic [(DATA_WIDTH/8)-1:0]             mem_be_o,
  input  logic [DATA_WIDTH-1:0]                 mem_data_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic                mem_en_q;
  logic [MEMORY_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [DATA_WIDTH-1:0]   core_data_q;

  logic [IDX_W-1:0]    grant_d;
  logic                grant_valid_d;
  logic [IDX_W:0]      sum;
  logic [IDX_W-1:0]    cand;
  logic [NUM_CORES-1:0] done_mask;

  // Winner search: scan offsets 0..N-1 from rr_ptr (round-robin) or from 0 (fixed priority).
  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
    grant_d       = '0;
    grant_valid_d = 1'b0;
    sum           = '0;
    cand          = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      sum = (IDX_W+1)'(off);
      if (ARB_MODE == 0) sum = sum + {1'b0, rr_ptr_q};
      if (sum >= (IDX_W+1)'(NUM_CORES)) sum = sum - (IDX_W+1)'(NUM_CORES);
      cand = sum[IDX_W-1:0];
      if (!grant_valid_d && core_req_i[cand]) begin
        grant_d       = cand;
        grant_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    done_mask = '0;
    if (state_q == ST_DONE) done_mask[grant_q] = 1'b1;
  end

  assign core_stall_o = core_req_i & ~done_mask;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_be_q    <= '0;
      core_data_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            grant_q    <= grant_d;
            mem_addr_q <= core_addr_i[grant_d*MEMORY_WIDTH +: MEMORY_WIDTH];
            mem_data_q <= core_data_i[grant_d*DATA_WIDTH +: DATA_WIDTH];
            mem_be_q   <= core_be_i[grant_d*BE_W +: BE_W];
            mem_en_q   <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt_q <= '0;
          state_q   <= (|mem_be_q) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          // The last WAIT cycle is the one where the memory presents valid read data.
          if (lat_cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
            core_data_q <= mem_data_i;
            state_q     <= ST_DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (ARB_MODE == 0)
            rr_ptr_q <= (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_be_o    = mem_be_q;
  assign core_data_o = core_data_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter. It runs a fixed-priority vector table, directed multi-cycle sequences,
// and random round-robin traffic compared against a transaction-level schedule model.
module tb_core_mem_arbiter;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int MW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam logic [DW-1:0] JUNK = 32'h0BAD_F00D;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [N-1:0]    req, stall;
  logic [N*MW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] be;
  logic [DW-1:0]   cdata, mdata, mrdata;
  logic            en;
  logic [MW-1:0]   maddr;
  logic [BW-1:0]   mbe;

  logic [N-1:0]    f_req, f_stall;
  logic [N*MW-1:0] f_addr;
  logic [N*DW-1:0] f_wdata;
  logic [N*BW-1:0] f_be;
  logic [DW-1:0]   f_cdata, f_mdata, f_mrdata;
  logic            f_en;
  logic [MW-1:0]   f_maddr;
  logic [BW-1:0]   f_mbe;

  core_mem_arbiter #(.NUM_CORES(N), .MEMORY_WIDTH(MW), .DATA_WIDTH(DW),
                     .MEM_LATENCY(L), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset(reset),
    .core_req_i(req), .core_addr_i(addr), .core_data_i(wdata), .core_be_i(be),
    .core_stall_o(stall), .core_data_o(cdata),
    .mem_en_o(en), .mem_addr_o(maddr), .mem_data_o(mdata), .mem_be_o(mbe),
    .mem_data_i(mrdata)
  );

  core_mem_arbiter #(.NUM_CORES(N), .MEMORY_WIDTH(MW), .DATA_WIDTH(DW),
                     .MEM_LATENCY(1), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset(reset),
    .core_req_i(f_req), .core_addr_i(f_addr), .core_data_i(f_wdata), .core_be_i(f_be),
    .core_stall_o(f_stall), .core_data_o(f_cdata),
    .mem_en_o(f_en), .mem_addr_o(f_maddr), .mem_data_o(f_mdata), .mem_be_o(f_mbe),
    .mem_data_i(f_mrdata)
  );

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] stall;
    logic         en;
    int           core;
  } vec_t;

  vec_t fp_vec [16];
  int n_tests = 0;
  int n_fail  = 0;

  // model state for the random phase
  int issue_c, done_c, idle_at, g, ptr, w;
  logic            is_read;
  logic [MW-1:0]   p_addr, exp_addr;
  logic [DW-1:0]   p_data, exp_data, exp_cdata, rd_val;
  logic [BW-1:0]   p_be, exp_be;
  logic [N-1:0]    exp_stall;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic cycle_start();
    @(posedge clock);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic [MW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[i] = r;
    addr[i*MW +: MW]  = a;
    wdata[i*DW +: DW] = d;
    be[i*BW +: BW]    = b;
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    cycle_start();
    reset = 1'b1;
  endtask

  task automatic new_req(input int i);
    logic [BW-1:0] b;
    b = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
    set_core(i, 1'b1, $urandom, $urandom, b);
  endtask

  // Read from core i: the request is seen in IDLE at c=0, ISSUE at c=1, and DONE at c=2+L.
  task automatic read_seq(input int i, input logic [MW-1:0] a, input logic [DW-1:0] v);
    set_core(i, 1'b1, a, 32'h0, 4'h0);
    for (int c = 0; c <= 2 + L; c++) begin
      mrdata = (c == 1 + L) ? v : JUNK;
      #1;
      check("rd_en", en, c == 1);
      check("rd_stall", stall[i], c < 2 + L);
      if (c == 1) begin
        check("rd_addr", maddr, a);
        check("rd_be", mbe, 0);
      end
      if (c == 2 + L) check("rd_data", cdata, v);
      cycle_start();
    end
    req[i] = 1'b0;
  endtask

  initial begin
    fp_vec[0]  = '{4'b0101, 4'b0101, 1'b0, -1};
    fp_vec[1]  = '{4'b0101, 4'b0101, 1'b1,  0};
    fp_vec[2]  = '{4'b0101, 4'b0100, 1'b0, -1};
    fp_vec[3]  = '{4'b0101, 4'b0101, 1'b0, -1};
    fp_vec[4]  = '{4'b0101, 4'b0101, 1'b1,  0};
    fp_vec[5]  = '{4'b0101, 4'b0100, 1'b0, -1};
    fp_vec[6]  = '{4'b0100, 4'b0100, 1'b0, -1};
    fp_vec[7]  = '{4'b0100, 4'b0100, 1'b1,  2};
    fp_vec[8]  = '{4'b0100, 4'b0000, 1'b0, -1};
    fp_vec[9]  = '{4'b0110, 4'b0110, 1'b0, -1};
    fp_vec[10] = '{4'b0110, 4'b0110, 1'b1,  1};
    fp_vec[11] = '{4'b0110, 4'b0100, 1'b0, -1};
    fp_vec[12] = '{4'b0100, 4'b0100, 1'b0, -1};
    fp_vec[13] = '{4'b0100, 4'b0100, 1'b1,  2};
    fp_vec[14] = '{4'b0100, 4'b0000, 1'b0, -1};
    fp_vec[15] = '{4'b0000, 4'b0000, 1'b0, -1};

    reset = 1'b0;
    req = '0; addr = '0; wdata = '0; be = '0; mrdata = '0;
    f_req = '0; f_mrdata = '0;
    for (int i = 0; i < N; i++) begin
      f_addr[i*MW +: MW]  = 32'h1000 + 16 * i;
      f_wdata[i*DW +: DW] = i;
      f_be[i*BW +: BW]    = 4'hF;
    end
    repeat (3) cycle_start();

    // Reset state. Stall must still follow the request while reset is held.
    set_core(0, 1'b1, 32'h40, 32'h0, 4'h0);
    set_core(2, 1'b1, 32'h48, 32'h0, 4'h0);
    #1;
    check("rst_stall", stall, 4'b0101);
    check("rst_en", en, 0);
    check("rst_addr", maddr, 0);
    check("rst_wdata", mdata, 0);
    check("rst_be", mbe, 0);
    check("rst_cdata", cdata, 0);
    check("rst_fp_en", f_en, 0);
    req   = '0;
    reset = 1'b1;

    // Fixed-priority vector table
    for (int k = 0; k < 16; k++) begin
      f_req = fp_vec[k].req;
      #1;
      check("fp_stall", f_stall, fp_vec[k].stall);
      check("fp_en", f_en, fp_vec[k].en);
      if (fp_vec[k].en) check("fp_addr", f_maddr, 32'h1000 + 16 * fp_vec[k].core);
      cycle_start();
    end

    read_seq(0, 32'h100, 32'hDEAD_BEEF);

    // Single write on core 1: it completes two cycles after the request, and the read data is held.
    set_core(1, 1'b1, 32'h20, 32'h0000_ABCD, 4'b0011);
    for (int c = 0; c <= 2; c++) begin
      #1;
      check("wr_en", en, c == 1);
      check("wr_stall", stall[1], c < 2);
      if (c == 1) begin
        check("wr_addr", maddr, 32'h20);
        check("wr_be", mbe, 4'b0011);
        check("wr_data", mdata, 32'h0000_ABCD);
      end
      if (c == 2) check("wr_cdata_hold", cdata, 32'hDEAD_BEEF);
      cycle_start();
    end
    req[1] = 1'b0;

    // Round-robin with four cores writing continuously from reset: grant order 0,1,2,3,0, one DONE every 3 cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 32'h200 + 4 * i, i, 4'hF);
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_stall = '1;
      if (c % 3 == 2) exp_stall[(c / 3) % N] = 1'b0;
      check("rr_en", en, c % 3 == 1);
      check("rr_stall", stall, exp_stall);
      if (c % 3 == 1) check("rr_addr", maddr, 32'h200 + 4 * ((c / 3) % N));
      cycle_start();
    end
    req = '0;

    // Reset in the second WAIT cycle abandons the read, and the late memory data is ignored.
    read_seq(3, 32'h300, 32'h1234_5678);
    set_core(0, 1'b1, 32'h104, 32'h0, 4'h0);
    for (int c = 0; c <= 5; c++) begin
      reset  = (c == 3) ? 1'b0 : 1'b1;
      mrdata = (c == 1 + L) ? 32'hCAFE_F00D : JUNK;
      #1;
      check("rw_stall", stall[0], 1);
      check("rw_en", en, (c == 1) || (c == 5));
      if (c == 2) check("rw_cdata_pre", cdata, 32'h1234_5678);
      if (c >= 4) check("rw_cdata_clr", cdata, 0);
      cycle_start();
    end
    req[0] = 1'b0;
    do_reset();

    // Core 1 pulses a request for one cycle while core 0 is in WAIT. Core 1 is never served and the FSM returns to IDLE.
    set_core(0, 1'b1, 32'h108, 32'h0, 4'h0);
    for (int c = 0; c <= 8; c++) begin
      set_core(1, c == 2, 32'h2222, 32'h0, 4'h0);
      if (c == 6) req[0] = 1'b0;
      mrdata = (c == 1 + L) ? 32'h55AA_55AA : JUNK;
      #1;
      check("dr_en", en, c == 1);
      check("dr_stall", stall, (c == 2) ? 4'b0011 : ((c < 5) ? 4'b0001 : 4'b0000));
      if (c == 5) check("dr_cdata", cdata, 32'h55AA_55AA);
      if (c == 8) check("dr_addr", maddr, 32'h108);
      cycle_start();
    end
    do_reset();

    // Random traffic checked against a schedule model that tracks the issue and done cycle numbers of each grant.
    issue_c = -1; done_c = -1; idle_at = 0; g = 0; ptr = 0; is_read = 1'b0;
    exp_addr = '0; exp_data = '0; exp_be = '0; exp_cdata = '0; rd_val = '0;
    p_addr = '0; p_data = '0; p_be = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) new_req(i);
        end else if (k == done_c + 1 && g == i) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          else new_req(i);
        end
      end
      mrdata = (is_read && k == done_c - 1) ? rd_val : $urandom;
      #1;
      if (k == issue_c) begin
        exp_addr = p_addr;
        exp_data = p_data;
        exp_be   = p_be;
      end
      exp_stall = req;
      if (k == done_c) begin
        if (is_read) exp_cdata = rd_val;
        ptr = (g + 1) % N;
        exp_stall[g] = 1'b0;
      end
      check("rnd_stall", stall, exp_stall);
      check("rnd_en", en, k == issue_c);
      check("rnd_addr", maddr, exp_addr);
      check("rnd_wdata", mdata, exp_data);
      check("rnd_be", mbe, exp_be);
      check("rnd_cdata", cdata, exp_cdata);
      if (k >= idle_at && req != '0) begin
        w = -1;
        for (int off = 0; off < N; off++)
          if (w < 0 && req[(ptr + off) % N]) w = (ptr + off) % N;
        g       = w;
        p_addr  = addr[w*MW +: MW];
        p_data  = wdata[w*DW +: DW];
        p_be    = be[w*BW +: BW];
        is_read = (p_be == '0);
        rd_val  = $urandom;
        issue_c = k + 1;
        done_c  = k + 2 + (is_read ? L : 0);
        idle_at = done_c + 1;
      end
      cycle_start();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
